serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled on the accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled on the accepted start.
REQ-007 SHALL have port cin  input  1  carry-in (borrow-in when sub=1), sampled on the accepted start.
REQ-008 SHALL have port sub  input  1  0 = add, 1 = subtract, sampled on the accepted start.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid new results.
REQ-011 SHALL have port s  output  WIDTH  result.
REQ-012 SHALL have port cout  output  1  final carry-out (1 = no borrow when sub=1).
REQ-013 SHALL have port zero  output  1  high when s equals 0.
REQ-014 SHALL have port ovf  output  1  signed overflow; present only with ADDSUB_OVF_EN.

Function
REQ-015 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored with no effect on the operation in flight.
REQ-017 SHALL, on the accepted start edge, latch a, b, cin and sub, clear the bit index to 0, and enter RUN.
REQ-018 SHALL use a single 1-bit full adder stage: per cycle, bit i = a[i] + (b[i] XOR sub) + carry. The initial carry is cin XOR sub.
REQ-019 SHALL process bit i, LSB first, in the i-th RUN cycle, writing result bit i and updating the carry register.
REQ-020 SHALL leave RUN after exactly WIDTH cycles and enter DONE for one cycle, then return to IDLE unless start is accepted.
REQ-021 SHALL assert busy in every RUN cycle only; done SHALL be high only in DONE.
REQ-022 SHALL achieve latency of WIDTH+1 cycles: done is high in the (WIDTH+1)th cycle after the start edge.
REQ-023 SHALL hold s, cout, zero and ovf stable from DONE until the next DONE; intermediate bits SHALL NOT be visible on s during RUN.
REQ-024 SHALL have arithmetic results (s, cout) equal {cout,s} = a + b + cin for sub=0, and a + ~b + ~cin for sub=1 (i.e. a - b - cin).
REQ-025 SHALL permit back-to-back operation: start high in DONE SHALL be accepted and enter RUN next cycle, with done still pulsing in that DONE cycle.
REQ-026 SHALL ignore inputs a, b, cin and sub changing during RUN.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, force IDLE with busy=0, done=0, s=0, cout=0, zero=1, ovf=0, and carry/index registers cleared.
REQ-028 SHALL, on reset during RUN or DONE, abort the operation with no done pulse; the first start after rst_n returns high SHALL behave as from power-up.

Configuration
REQ-029 SHALL use macro ADDSUB_OVF_EN to control the ovf feature.
REQ-030 SHALL, with ADDSUB_OVF_EN defined, provide port ovf = carry into MSB XOR carry out of MSB, updated with the other results in DONE.
REQ-031 SHALL, without ADDSUB_OVF_EN, omit the ovf port and its logic entirely, with all other behaviour unchanged.

Verification (WIDTH=8)
REQ-032 SHALL cover: a=0x05, b=0x03, cin=0, sub=0 -> s=0x08, cout=0, zero=0, done exactly 9 cycles after start.
REQ-033 SHALL cover: a=0xFF, b=0x01, cin=0, sub=0 -> s=0x00, cout=1, zero=1. Then a=0x10, b=0x01, sub=1, cin=0 -> s=0x0F, cout=1.
REQ-034 SHALL cover: a=0x01, b=0x02, sub=1, cin=1 -> s=0xFE, cout=0. With ADDSUB_OVF_EN: a=0x7F, b=0x01, sub=0 -> s=0x80, ovf=1.
REQ-035 SHALL cover: start pulsed again at cycle 3 of RUN with new operands -> ignored, first result unchanged. Start held high through DONE -> second op accepted, second done 9 cycles later.
REQ-036 SHALL cover: rst_n=0 at cycle 4 of RUN -> next edge busy=0, s=0x00, zero=1, no done pulse. Next op after release gives correct result.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder stage, LSB first, WIDTH+1 latency.
// Define ADDSUB_OVF_EN to add the signed-overflow output ovf.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef ADDSUB_OVF_EN
    output logic             zero,
    output logic             ovf
`else
    output logic             zero
`endif
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] acc;
    logic [IW-1:0]    idx;
    logic             sub_r;
    logic             carry;

    logic             bx;
    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        bx        = op_b[0] ^ sub_r;
        sum_bit   = op_a[0] ^ bx ^ carry;
        carry_nxt = (op_a[0] & bx) | (carry & (op_a[0] ^ bx));
        // New bit enters at the top; after WIDTH shifts bit 0 sits at the LSB.
        res_nxt   = {sum_bit, acc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            zero  <= 1'b1;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            idx   <= '0;
            sub_r <= 1'b0;
            carry <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        sub_r <= sub;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    acc   <= res_nxt[WIDTH-1:1];
                    carry <= carry_nxt;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= res_nxt;
                        cout  <= carry_nxt;
                        zero  <= (res_nxt == '0);
`ifdef ADDSUB_OVF_EN
                        ovf   <= carry ^ carry_nxt;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
